// File: rtl/pid_term_sequencer.sv
// Sequences one shared repeated-add multiplier over the P, I and D terms of a PID update.
// Optional build macro INTEGRATOR_SAT_EN: the integral sum saturates at 63 instead of wrapping.
module pid_term_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       start,
    input  logic [5:0] e,
    input  logic [5:0] K_p,
    input  logic [5:0] K_i,
    input  logic [5:0] K_d,
    output logic       busy,
    output logic       valid,
    output logic [5:0] u,
    output logic       sat
);

    localparam int unsigned W  = 6;
    localparam int unsigned AW = 14;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_MUL_P = 3'd2;
    localparam logic [2:0] S_MUL_I = 3'd3;
    localparam logic [2:0] S_MUL_D = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]    state_q,  state_d;
    logic [W-1:0]  e_sum_q,  e_sum_d;
    logic [W-1:0]  e_prev_q, e_prev_d;
    logic [W-1:0]  op_p_q,   op_p_d;
    logic [W-1:0]  op_i_q,   op_i_d;
    logic [W-1:0]  op_d_q,   op_d_d;
    logic [W-1:0]  ki_q,     ki_d;
    logic [W-1:0]  kd_q,     kd_d;
    logic [W-1:0]  cnt_q,    cnt_d;
    logic [AW-1:0] acc_q,    acc_d;
    logic          busy_q,   busy_d;
    logic          valid_q,  valid_d;
    logic [W-1:0]  u_q,      u_d;
    logic          sat_q,    sat_d;

    logic [W-1:0]  esum_new;
    logic [W-1:0]  op_sel;
    logic [AW-1:0] acc_fin;
    logic          cnt_last;

`ifdef INTEGRATOR_SAT_EN
    logic [W:0] esum_wide;
    always_comb begin
        esum_wide = {1'b0, e_sum_q} + {1'b0, e};
        esum_new  = esum_wide[W] ? {W{1'b1}} : esum_wide[W-1:0];
    end
`else
    always_comb begin
        esum_new = W'(e_sum_q + e);
    end
`endif

    // Datapath helpers: operand for the active term and accumulator after this cycle's add.
    always_comb begin
        case (state_q)
            S_MUL_P: op_sel = op_p_q;
            S_MUL_I: op_sel = op_i_q;
            default: op_sel = op_d_q;
        endcase
        acc_fin  = (cnt_q != '0) ? acc_q + AW'(op_sel) : acc_q;
        cnt_last = (cnt_q <= W'(1));
    end

    always_comb begin
        state_d  = state_q;
        e_sum_d  = e_sum_q;
        e_prev_d = e_prev_q;
        op_p_d   = op_p_q;
        op_i_d   = op_i_q;
        op_d_d   = op_d_q;
        ki_d     = ki_q;
        kd_d     = kd_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        busy_d   = busy_q;
        valid_d  = valid_q;
        u_d      = u_q;
        sat_d    = sat_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    busy_d  = 1'b1;
                end
            end
            S_LOAD: begin
                e_sum_d  = esum_new;
                op_p_d   = e;
                op_i_d   = esum_new;
                op_d_d   = (e > e_prev_q) ? W'(e - e_prev_q) : '0;
                e_prev_d = e;
                acc_d    = '0;
                cnt_d    = K_p;
                ki_d     = K_i;
                kd_d     = K_d;
                state_d  = S_MUL_P;
            end
            S_MUL_P, S_MUL_I, S_MUL_D: begin
                acc_d = acc_fin;
                cnt_d = (cnt_q != '0) ? W'(cnt_q - W'(1)) : cnt_q;
                // A zero gain still spends one cycle here, adding nothing.
                if (cnt_last) begin
                    if (state_q == S_MUL_P) begin
                        state_d = S_MUL_I;
                        cnt_d   = ki_q;
                    end else if (state_q == S_MUL_I) begin
                        state_d = S_MUL_D;
                        cnt_d   = kd_q;
                    end else begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                        valid_d = 1'b1;
                        sat_d   = (acc_fin > AW'(63));
                        u_d     = (acc_fin > AW'(63)) ? {W{1'b1}} : acc_fin[W-1:0];
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    // Synchronous reset wins over the clock enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            e_sum_q  <= '0;
            e_prev_q <= '0;
            op_p_q   <= '0;
            op_i_q   <= '0;
            op_d_q   <= '0;
            ki_q     <= '0;
            kd_q     <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            u_q      <= '0;
            sat_q    <= 1'b0;
        end else if (ena) begin
            state_q  <= state_d;
            e_sum_q  <= e_sum_d;
            e_prev_q <= e_prev_d;
            op_p_q   <= op_p_d;
            op_i_q   <= op_i_d;
            op_d_q   <= op_d_d;
            ki_q     <= ki_d;
            kd_q     <= kd_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            u_q      <= u_d;
            sat_q    <= sat_d;
        end
    end

    assign busy  = busy_q;
    assign valid = valid_q;
    assign u     = u_q;
    assign sat   = sat_q;

endmodule

// File: tb/tb_pid_term_sequencer.sv
// Directed bench for pid_term_sequencer: latency, result, saturation, stall and reset behaviour.
module tb_pid_term_sequencer;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       start;
    logic [5:0] e;
    logic [5:0] K_p;
    logic [5:0] K_i;
    logic [5:0] K_d;
    logic       busy;
    logic       valid;
    logic [5:0] u;
    logic       sat;

    int n_vec;
    int n_mis;

    pid_term_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .start (start),
        .e     (e),
        .K_p   (K_p),
        .K_i   (K_i),
        .K_d   (K_d),
        .busy  (busy),
        .valid (valid),
        .u     (u),
        .sat   (sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        ena   = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, ".busy"},  int'(busy),  0);
        chk({tag, ".valid"}, int'(valid), 0);
        chk({tag, ".u"},     int'(u),     0);
        chk({tag, ".sat"},   int'(sat),   0);
        @(negedge clk);
        rst_n = 1'b1;
        ena   = 1'b1;
    endtask

    // Issue one update, optionally stalling ena for stall_len cycles starting stall_at edges after accept.
    task automatic run_update(input string tag, input logic [5:0] ev, input logic [5:0] kp,
                              input logic [5:0] ki, input logic [5:0] kd,
                              input int stall_at, input int stall_len,
                              input int exp_u, input int exp_sat, input int exp_l);
        int  n;
        bit  got;
        n   = 0;
        got = 1'b0;
        @(negedge clk);
        e     = ev;
        K_p   = kp;
        K_i   = ki;
        K_d   = kd;
        start = 1'b1;
        ena   = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, ".busy_rise"}, int'(busy), 1);
        while (!got && n < 400) begin
            @(negedge clk);
            if (n >= 1) begin
                e   = ~ev;
                K_p = ~kp;
                K_i = ~ki;
                K_d = ~kd;
            end
            ena   = !(n >= stall_at && n < stall_at + stall_len);
            start = (n == 1) || !ena;
            @(posedge clk);
            n++;
            #1;
            if (valid) got = 1'b1;
        end
        chk({tag, ".latency"}, n, exp_l);
        chk({tag, ".u"},       int'(u),   exp_u);
        chk({tag, ".sat"},     int'(sat), exp_sat);
        @(negedge clk);
        ena   = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, ".valid_drop"}, int'(valid), 0);
        chk({tag, ".busy_drop"},  int'(busy),  0);
        chk({tag, ".u_hold"},     int'(u),     exp_u);
    endtask

    initial begin
        int extra_valid;
        int busy_seen;
        clk   = 1'b0;
        rst_n = 1'b1;
        ena   = 1'b1;
        start = 1'b0;
        e     = '0;
        K_p   = '0;
        K_i   = '0;
        K_d   = '0;
        n_vec = 0;
        n_mis = 0;

        do_reset("rst0");
        // 5*2 + 5*1 + 0 = 15
        run_update("t1", 6'd5, 6'd2, 6'd1, 6'd0, -1, 0, 15, 0, 5);
        // e_sum=8, falling error so no D term: 3*2 + 8 = 14
        run_update("t2", 6'd3, 6'd2, 6'd1, 6'd0, -1, 0, 14, 0, 5);

        do_reset("rst1");
        run_update("t3", 6'd63, 6'd63, 6'd63, 6'd63, -1, 0, 63, 1, 190);

        do_reset("rst2");
        run_update("t4a", 6'd40, 6'd0, 6'd1, 6'd0, -1, 0, 40, 0, 4);
`ifdef INTEGRATOR_SAT_EN
        run_update("t4b", 6'd40, 6'd0, 6'd1, 6'd0, -1, 0, 63, 0, 4);
`else
        run_update("t4b", 6'd40, 6'd0, 6'd1, 6'd0, -1, 0, 16, 0, 4);
`endif

        do_reset("rst3");
        // ena low for 3 cycles while in MUL_I, start pulsed while busy
        run_update("t5", 6'd5, 6'd2, 6'd1, 6'd0, 3, 3, 15, 0, 8);
        extra_valid = 0;
        busy_seen   = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (valid) extra_valid++;
            if (busy) busy_seen++;
        end
        chk("t5.no_second_valid", extra_valid, 0);
        chk("t5.no_second_busy",  busy_seen,   0);

        // Reset mid MUL_P, with ena low to show reset priority
        @(negedge clk);
        e     = 6'd20;
        K_p   = 6'd10;
        K_i   = 6'd1;
        K_d   = 6'd1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("t6.busy_mid", int'(busy), 1);
        do_reset("t6.rst");
        run_update("t6.after", 6'd5, 6'd0, 6'd1, 6'd0, -1, 0, 5, 0, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
